addr_cvt_sched: RTL and testbench



---
 rtl/addr_cvt_sched.sv | 120 ++++++++++++
 tb/tb_addr_cvt_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/addr_cvt_sched.sv
// Job sequencer for the addr_cvt converter: scans a (Bx, By) tile in row-major
// order, bounds in-flight conversions with a credit counter, forwards results.
//
// state | meaning
// IDLE  | waiting for start; parameters latched on an accepted start
// ISSUE | presenting coordinates while credits are available
// DRAIN | all coordinates issued, waiting for outstanding results
// DONE  | one-cycle completion pulse
module addr_cvt_sched #(
  parameter int CW      = 16,
  parameter int MAX_OUT = 4,
  parameter int OW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] bx0,
  input  logic [CW-1:0] by0,
  input  logic [CW-1:0] n_cols,
  input  logic [CW-1:0] n_rows,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] Bx,
  output logic [CW-1:0] By,
  output logic          dma_req,
  input  logic          dma_ready,
  input  logic          req_valid,
  input  logic [31:0]   addr,
  output logic          req_ready,
  output logic          out_valid,
  output logic [31:0]   out_addr,
  input  logic          out_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] bx_q, by_q, bx0_q, n_cols_q, col_rem_q, row_rem_q;
  logic [OW-1:0] out_cnt_q;
  logic          issue_acc, res_hs, last_elem, start_acc;

  assign out_valid = req_valid;
  assign out_addr  = addr;
  assign req_ready = out_ready;

  assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign dma_req   = (state_q == ISSUE) && (out_cnt_q < OW'(MAX_OUT));
  assign Bx        = bx_q;
  assign By        = by_q;

  assign issue_acc = dma_req && dma_ready;
  assign res_hs    = req_valid && out_ready;
  assign start_acc = (state_q == IDLE) && start;
  assign last_elem = (col_rem_q == CW'(1)) && (row_rem_q == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((n_cols == '0) || (n_rows == '0)) state_d = DONE;
          else                                  state_d = ISSUE;
        end
      end
      ISSUE:   if (issue_acc && last_elem) state_d = DRAIN;
      DRAIN:   if (out_cnt_q == '0)        state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Termination relies on the remaining counts, so coordinate wrap is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bx_q      <= '0;
      by_q      <= '0;
      bx0_q     <= '0;
      n_cols_q  <= '0;
      col_rem_q <= '0;
      row_rem_q <= '0;
    end else if (start_acc) begin
      bx_q      <= bx0;
      by_q      <= by0;
      bx0_q     <= bx0;
      n_cols_q  <= n_cols;
      col_rem_q <= n_cols;
      row_rem_q <= n_rows;
    end else if (issue_acc) begin
      if (col_rem_q > CW'(1)) begin
        bx_q      <= bx_q + CW'(1);
        col_rem_q <= col_rem_q - CW'(1);
      end else begin
        bx_q      <= bx0_q;
        by_q      <= by_q + CW'(1);
        col_rem_q <= n_cols_q;
        row_rem_q <= row_rem_q - CW'(1);
      end
    end
  end

  // Stray results with no credit in use saturate at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt_q <= '0;
    end else begin
      case ({issue_acc, res_hs})
        2'b10:   out_cnt_q <= out_cnt_q + OW'(1);
        2'b01:   if (out_cnt_q != '0) out_cnt_q <= out_cnt_q - OW'(1);
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_cvt_sched.sv
// Randomized bench for addr_cvt_sched: expected coordinate order, credit limit,
// busy/done timing and forwarding come from a queue-based job model.
module tb_addr_cvt_sched;
  localparam int CW = 16, MAX_OUT = 4, OW = 4;

  logic          clk = 1'b0, rst;
  logic          start, busy, done, dma_req, dma_ready, req_valid, req_ready;
  logic          out_valid, out_ready;
  logic [CW-1:0] bx0, by0, n_cols, n_rows, Bx, By;
  logic [31:0]   addr, out_addr;

  addr_cvt_sched #(.CW(CW), .MAX_OUT(MAX_OUT), .OW(OW)) dut (
    .clk(clk), .rst(rst), .start(start), .bx0(bx0), .by0(by0),
    .n_cols(n_cols), .n_rows(n_rows), .busy(busy), .done(done),
    .Bx(Bx), .By(By), .dma_req(dma_req), .dma_ready(dma_ready),
    .req_valid(req_valid), .addr(addr), .req_ready(req_ready),
    .out_valid(out_valid), .out_addr(out_addr), .out_ready(out_ready));

  always #5 clk = ~clk;

  typedef struct {logic [15:0] x; logic [15:0] y;} xy_t;
  typedef struct {logic [31:0] a; int t;} pend_t;

  int checks = 0, failures = 0;
  int cyc = 0;
  xy_t   exp_q[$];
  pend_t pend_q[$];
  logic [31:0] fwd_q[$];
  int m_out = 0, m_active = 0, m_done_at = -1, busy_until = 0;
  int rdy_pct = 100, out_pct = 100, out_block = 0;
  int n_issued, n_fwd, n_done;
  bit prev_stall = 0;
  logic [31:0] prev_xy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] cvt(input logic [15:0] x, input logic [15:0] y);
    return {y, x} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic step(input bit do_start, input logic [15:0] sbx, input logic [15:0] sby,
                      input logic [15:0] snc, input logic [15:0] snr);
    bit accept, exp_req;
    logic [31:0] a;
    @(negedge clk);
    cyc++;
    accept    = do_start && (m_active == 0) && (m_done_at < 0);
    start     = do_start;
    bx0       = sbx;  by0 = sby;  n_cols = snc;  n_rows = snr;
    dma_ready = ($urandom_range(99) < rdy_pct);
    out_ready = (out_block > 0) ? 1'b0 : ($urandom_range(99) < out_pct);
    if (out_block > 0) out_block--;
    req_valid = (pend_q.size() > 0) && (pend_q[0].t <= cyc);
    addr      = req_valid ? pend_q[0].a : $urandom();
    #1;
    check("busy", busy, (m_active != 0) && (m_done_at < 0 || cyc <= busy_until));
    check("done", done, cyc == m_done_at);
    exp_req = (m_active != 0) && (exp_q.size() > 0) && (m_out < MAX_OUT);
    check("dma_req", dma_req, exp_req);
    check("pass", {out_valid, req_ready, out_addr}, {req_valid, out_ready, addr});
    if (prev_stall) check("hold", {Bx, By}, prev_xy);
    prev_stall = dma_req && !dma_ready;
    prev_xy    = {Bx, By};
    if (dma_req && dma_ready) begin
      if (exp_q.size() == 0) check("issue_extra", dma_req, 1'b0);
      else begin
        xy_t e = exp_q.pop_front();
        check("issue_xy", {Bx, By}, {e.x, e.y});
      end
      pend_q.push_back('{cvt(Bx, By), cyc + 2});
      fwd_q.push_back(cvt(Bx, By));
      m_out++;
      n_issued++;
    end
    if (req_valid && req_ready) begin
      a = fwd_q.pop_front();
      check("fwd_addr", out_addr, a);
      void'(pend_q.pop_front());
      m_out--;
      n_fwd++;
    end
    if (done) n_done++;
    if (cyc == m_done_at) begin
      m_done_at = -1;
      m_active  = 0;
    end
    if (m_active != 0 && m_done_at < 0 && exp_q.size() == 0 && m_out == 0) begin
      busy_until = cyc + 1;
      m_done_at  = cyc + 2;
    end
    if (accept) begin
      if (snc == 0 || snr == 0) m_done_at = cyc + 1;
      else begin
        for (int r = 0; r < int'(snr); r++)
          for (int c = 0; c < int'(snc); c++)
            exp_q.push_back('{16'(sbx + 16'(c)), 16'(sby + 16'(r))});
        m_active = 1;
      end
    end
  endtask

  task automatic start_job(input logic [15:0] sbx, input logic [15:0] sby,
                           input logic [15:0] snc, input logic [15:0] snr);
    n_issued = 0; n_fwd = 0; n_done = 0;
    step(1'b1, sbx, sby, snc, snr);
  endtask

  task automatic finish_job(input int total, input int restart_at);
    int k = 0;
    while ((m_active != 0 || m_done_at >= 0) && k < 3000) begin
      step(k == restart_at, 16'($urandom()), 16'($urandom()), 16'd2, 16'd2);
      k++;
    end
    check("job_timeout", (m_active != 0 || m_done_at >= 0), 1'b0);
    check("n_issued", n_issued, total);
    check("n_fwd", n_fwd, total);
    check("n_done", n_done, 1);
  endtask

  initial begin
    rst = 1'b1; start = 0; bx0 = 0; by0 = 0; n_cols = 0; n_rows = 0;
    dma_ready = 0; req_valid = 0; addr = 0; out_ready = 0;
    @(negedge clk); #1;
    check("rst_outs", {busy, done, dma_req, Bx, By}, '0);
    @(negedge clk); rst = 1'b0;

    // Basic tile with ideal converter and consumer
    start_job(16'd2399, 16'd728, 16'd3, 16'd2);
    finish_job(6, -1);

    // Empty jobs
    start_job(16'd5, 16'd5, 16'd0, 16'd4);
    finish_job(0, -1);
    start_job(16'd5, 16'd5, 16'd4, 16'd0);
    finish_job(0, -1);

    // Credit stall: consumer blocked for 20 cycles
    out_block = 20;
    start_job(16'd100, 16'd200, 16'd4, 16'd3);
    for (int i = 0; i < 19; i++) step(1'b0, 0, 0, 0, 0);
    check("credit_cap", n_issued, MAX_OUT);
    finish_job(12, -1);

    // dma_ready stalls plus a stray start mid-job
    rdy_pct = 50;
    start_job(16'd10, 16'd20, 16'd4, 16'd3);
    finish_job(12, 3);
    rdy_pct = 100;

    // Coordinate wrap
    start_job(16'hFFFE, 16'hFFFF, 16'd3, 16'd2);
    finish_job(6, -1);

    // Reset mid-job with 2 outstanding
    out_block = 50;
    start_job(16'd1, 16'd1, 16'd3, 16'd3);
    for (int i = 0; i < 50 && m_out != 2; i++) step(1'b0, 0, 0, 0, 0);
    check("pre_rst_out", m_out, 2);
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; #1;
    check("rst_mid", {busy, done, dma_req, Bx, By}, '0);
    exp_q.delete(); pend_q.delete(); fwd_q.delete();
    m_out = 0; m_active = 0; m_done_at = -1; out_block = 0; prev_stall = 0;
    @(negedge clk); #1;
    check("rst_hold", {busy, done, dma_req}, '0);
    rst = 1'b0;
    out_block = 20;
    start_job(16'd7, 16'd9, 16'd3, 16'd3);
    for (int i = 0; i < 19; i++) step(1'b0, 0, 0, 0, 0);
    check("post_rst_cap", n_issued, MAX_OUT);
    finish_job(9, -1);

    // Randomized jobs
    rdy_pct = 70; out_pct = 70;
    for (int j = 0; j < 20; j++) begin
      logic [15:0] rbx, rby, rnc, rnr;
      rbx = ($urandom_range(3) == 0) ? 16'(16'hFFFF - 16'($urandom_range(3))) : 16'($urandom());
      rby = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom());
      rnc = 16'($urandom_range(5));
      rnr = 16'($urandom_range(4));
      start_job(rbx, rby, rnc, rnr);
      finish_job(int'(rnc) * int'(rnr), (j % 3 == 0) ? 2 : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
